// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, sign fixed in FIX.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t state, state_nx;

  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   opb, dvd;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_res, neg_rem, dz;

  logic               go, go_md, op_sgn, op_div;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  assign busy = (state != IDLE);
  assign go   = start && !flush && (state == IDLE);

  always_comb begin
    go_md  = 1'b0;
    op_sgn = 1'b0;
    op_div = 1'b0;
    unique case (1'b1)
      (mdOp == OP_MULT):  begin go_md = go; op_sgn = 1'b1; end
      (mdOp == OP_MULTU): go_md = go;
      (mdOp == OP_DIV):   begin
        go_md = go; op_sgn = 1'b1; op_div = 1'b1;
      end
      (mdOp == OP_DIVU):  begin go_md = go; op_div = 1'b1; end
      default: ;
    endcase
  end

  // Magnitudes fit WIDTH bits unsigned, so the most-negative case is exact.
  assign a_abs = (op_sgn && din1[WIDTH-1]) ? -din1 : din1;
  assign b_abs = (op_sgn && din2[WIDTH-1]) ? -din2 : din2;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opb} : '0);
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};

  always_comb begin
    acc_nx = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH])
        acc_nx = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nx = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  assign prod = neg_res ? -acc : acc;
  assign quot = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_lo = dz ? '1 : (neg_res ? -quot : quot);
      res_hi = dz ? dvd : (neg_rem ? -rem : rem);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go_md) state_nx = CALC;
      CALC: if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      opb       <= '0;
      dvd       <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dz        <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      if (go_md) begin
        acc     <= {{WIDTH{1'b0}}, op_div ? a_abs : b_abs};
        opb     <= op_div ? b_abs : a_abs;
        dvd     <= din1;
        cnt     <= CNT_W'(WIDTH);
        is_div  <= op_div;
        neg_res <= op_sgn && (din1[WIDTH-1] ^ din2[WIDTH-1]);
        neg_rem <= op_sgn && din1[WIDTH-1];
        dz      <= op_div && (din2 == '0);
      end
      if (go && mdOp == OP_MTHI) hi <= din1;
      if (go && mdOp == OP_MTLO) lo <= din1;
      if (state == CALC && !flush) begin
        acc <= acc_nx;
        cnt <= cnt - CNT_W'(1);
      end
      if (state == FIX && !flush) begin
        hi        <= res_hi;
        lo        <= res_lo;
        done      <= 1'b1;
        divByZero <= is_div && dz;
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the EX stage and executes mult, multu, div, divu, mthi and mtlo. Multiply and divide run as multi-cycle operations under a start/busy/done handshake, so the pipeline stalls on busy. It adds a flush input for exception squash and a divide-by-zero flag, neither of which the ALU has.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be >= 4)
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; samples mdOp/din1/din2 when high and busy=0
mdOp  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
din1  input  WIDTH  rs operand: multiplicand/dividend, or mthi/mtlo source
din2  input  WIDTH  rt operand: multiplier/divisor
flush  input  1  abort the in-flight operation
busy  output  1  high while a multiply/divide is in flight
done  output  1  one-cycle pulse when HI/LO are updated by a multiply/divide
divByZero  output  1  valid with done; 1 if a div/divu had din2=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; hi=0; lo=0; busy=0; done=0; divByZero=0; counter=0. Reset mid-operation aborts immediately. HI/LO are not written from partial results.
- FSM states are IDLE, CALC and FIX. busy = (state != IDLE), driven from registers.
- IDLE, start=1, mdOp in {mult, multu, div, divu}:
  - Latch operands.
  - For signed ops, latch absolute values plus the result sign and remainder sign.
  - Set counter=WIDTH and go to CALC.
- IDLE, start=1, mdOp=mthi: hi<=din1 at that edge; lo unchanged. mdOp=mtlo is the same for lo. Neither asserts busy or done.
- IDLE, start=1, mdOp none or reserved: no effect.
- CALC runs one radix-2 step per cycle and decrements the counter. On the step where counter reaches 1, go to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, giving a WIDTH-bit quotient and remainder.
- FIX (1 cycle):
  - Apply sign correction: two's-complement negate of the product, quotient or remainder as required.
  - Write hi/lo at the edge leaving FIX, then go to IDLE.
  - done=1 and divByZero valid for exactly the one cycle after that edge.
- Latency: start sampled at edge k; hi/lo updated and busy falls at edge k+WIDTH+1; done is high in cycle k+WIDTH+1. Busy is high for WIDTH+1 cycles.
- Results:
  - mult/multu: {hi,lo} = full 2*WIDTH product, signed or unsigned.
  - div/divu: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Boundaries:
  - Divisor 0: hi=din1 (dividend, uncorrected), lo=all ones, divByZero=1. Applies to both div and divu; the sign fixup is suppressed.
  - Signed most-negative / -1: lo=most-negative (0x8000_0000), hi=0, no flag, no exception.
  - Most-negative operands in mult: the product must be exact; use a WIDTH+1-bit magnitude path where needed.
- start while busy: ignored, no queueing; this includes mthi/mtlo. The pipeline is required to stall.
- flush=1 (any state): go to IDLE at the next edge. hi/lo are unchanged and no done pulse is produced.
  - flush and start in the same IDLE cycle: flush wins and the start is ignored, including mthi/mtlo.
  - flush in the FIX cycle: the write is suppressed.
- Operands changing while busy have no effect.

Test Plan:
- Signed multiply: mult, din1=0xFFFFFFFF, din2=2 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE; done pulses exactly one cycle; busy high exactly 33 cycles.
- Unsigned multiply and extremes:
  - multu, din1=0xFFFFFFFF, din2=2 -> hi=0x00000001, lo=0xFFFFFFFE.
  - mult, 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- Signed divide and overflow case:
  - div, din1=-7 (0xFFFFFFF9), din2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div, 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu, din1=7, din2=0 -> hi=7, lo=0xFFFFFFFF, divByZero=1 in the done cycle. A following divu 7/2 gives lo=3, hi=1, divByZero=0.
- mthi/mtlo and start-while-busy:
  - mthi 0x12345678 then mtlo 0x9ABCDEF0 -> HI/LO update on the next edge with busy=0.
  - mtlo 0x1 issued while busy -> ignored; the final lo is the multiply result.
- Abort paths:
  - flush 10 cycles into a mult -> busy=0 next cycle, hi/lo keep prior values, no done.
  - rst_n low mid-div -> hi=lo=0 and busy=0 immediately (asynchronous).
